// File: rtl/opponent_link_rx_if.sv
// rtl/opponent_link_rx_if.sv - raw opponent link lines in, clean move/reset events out
interface opponent_link_rx_if;
  logic [3:0] oppo_chesspos_rx;
  logic       oppo_click_rx;
  logic       globalReset_rx;
  logic       regReset_rx;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_reject;
  logic [7:0] reject_count;
  logic       globalReset_req;
  logic       regReset_req;

  modport slave (
    input  oppo_chesspos_rx, oppo_click_rx, globalReset_rx, regReset_rx,
    output move_valid, move_pos, move_reject, reject_count, globalReset_req, regReset_req
  );

  modport master (
    output oppo_chesspos_rx, oppo_click_rx, globalReset_rx, regReset_rx,
    input  move_valid, move_pos, move_reject, reject_count, globalReset_req, regReset_req
  );
endinterface

// File: rtl/opponent_link_rx.sv
// rtl/opponent_link_rx.sv - synchronise, debounce and validate opponent link lines
module opponent_link_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int POS_TIMEOUT   = 64,
  parameter int MAX_CELL      = 8
) (
  input  logic               clock,
  input  logic               reset,
  opponent_link_rx_if.slave  link
);
  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(POS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_POS, WAIT_RELEASE} state_t;

  // bit layout: [3:0] position, [4] click, [5] register reset, [6] global reset
  logic [6:0]     raw;
  logic [6:0]     sync_q [SYNC_STAGES];
  logic [2:0]     line_s;
  logic [3:0]     pos_s;
  logic [3:0]     pos_prev;
  logic [2:0]     filt;
  logic [SCW-1:0] fcnt [3];
  logic [SCW-1:0] pcnt;
  logic           pos_stable;
  logic           click_d;
  logic           click_rise;
  logic           greq;
  state_t         state, state_n;
  logic [TCW-1:0] tcnt, tcnt_n;
  logic           do_eval, do_timeout, accept, reject;
  logic           move_valid_q, move_reject_q;
  logic [3:0]     move_pos_q;
  logic [7:0]     reject_count_q;

  assign raw        = {link.globalReset_rx, link.regReset_rx, link.oppo_click_rx, link.oppo_chesspos_rx};
  assign line_s     = sync_q[SYNC_STAGES-1][6:4];
  assign pos_s      = sync_q[SYNC_STAGES-1][3:0];
  assign pos_stable = (pcnt == SCW'(STABLE_CYCLES));
  assign greq       = filt[2];
  assign click_rise = filt[0] & ~click_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A filtered line only moves after STABLE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (!reset) begin
      filt    <= '0;
      click_d <= 1'b0;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      click_d <= filt[0];
      for (int i = 0; i < 3; i++) begin
        if (line_s[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == SCW'(STABLE_CYCLES - 1)) begin
          filt[i] <= line_s[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_prev <= '0;
      pcnt     <= '0;
    end else begin
      pos_prev <= pos_s;
      if (pos_s != pos_prev)    pcnt <= '0;
      else if (!pos_stable)     pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    do_eval    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (click_rise) begin
          if (pos_stable) begin
            do_eval = 1'b1;
            state_n = WAIT_RELEASE;
          end else begin
            state_n = WAIT_POS;
            tcnt_n  = '0;
          end
        end
      end
      WAIT_POS: begin
        if (pos_stable) begin
          do_eval = 1'b1;
          state_n = WAIT_RELEASE;
        end else if (tcnt == TCW'(POS_TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_n    = WAIT_RELEASE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!filt[0]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A pending global reset swallows any click in flight.
    if (greq) begin
      state_n    = IDLE;
      do_eval    = 1'b0;
      do_timeout = 1'b0;
    end
  end

  assign accept = do_eval && (pos_s <= 4'(MAX_CELL));
  assign reject = do_timeout || (do_eval && (pos_s > 4'(MAX_CELL)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      move_valid_q   <= 1'b0;
      move_reject_q  <= 1'b0;
      move_pos_q     <= '0;
      reject_count_q <= '0;
    end else begin
      move_valid_q  <= accept;
      move_reject_q <= reject;
      if (greq) begin
        move_pos_q     <= '0;
        reject_count_q <= '0;
      end else begin
        if (accept) move_pos_q <= pos_s;
        if (reject && reject_count_q != 8'hFF) reject_count_q <= reject_count_q + 8'd1;
      end
    end
  end

  assign link.move_valid      = move_valid_q;
  assign link.move_reject     = move_reject_q;
  assign link.move_pos        = move_pos_q;
  assign link.reject_count    = reject_count_q;
  assign link.globalReset_req = filt[2];
  assign link.regReset_req    = filt[1];
endmodule

// File: tb/tb_opponent_link_rx.sv
// tb/tb_opponent_link_rx.sv - scoreboard bench for opponent_link_rx
module tb_opponent_link_rx;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    bit         is_valid;
    logic [3:0] pos;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  exp_t sbq[$];

  opponent_link_rx_if lnk ();

  opponent_link_rx dut (
    .clock (clock),
    .reset (reset),
    .link  (lnk)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_event(input bit is_valid, input logic [3:0] pos, input logic [7:0] cnt, input int lat);
    exp_t e;
    e.is_valid = is_valid;
    e.pos      = pos;
    e.cnt      = cnt;
    e.due      = (lat < 0) ? -1 : cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic toggle_pos(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 5 == 0) lnk.oppo_chesspos_rx = (lnk.oppo_chesspos_rx == 4'd1) ? 4'd3 : 4'd1;
      tick(1);
    end
  endtask

  always @(negedge clock) begin
    if (reset && (lnk.move_valid || lnk.move_reject)) begin
      if (sbq.size() == 0) begin
        check("unexpected_event", {30'd0, lnk.move_valid, lnk.move_reject}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("event_exclusive", {31'd0, lnk.move_valid & lnk.move_reject}, 32'd0);
        check("event_kind", {31'd0, lnk.move_valid}, {31'd0, e.is_valid});
        check("event_pos", {28'd0, lnk.move_pos}, {28'd0, e.pos});
        check("event_count", {24'd0, lnk.reject_count}, {24'd0, e.cnt});
        if (e.due >= 0) check("event_latency", cyc, e.due);
      end
    end
  end

  initial begin
    lnk.oppo_chesspos_rx = 4'd0;
    lnk.oppo_click_rx    = 1'b0;
    lnk.globalReset_rx   = 1'b0;
    lnk.regReset_rx      = 1'b0;
    tick(3);
    check("rst_move_valid", {31'd0, lnk.move_valid}, 32'd0);
    check("rst_move_reject", {31'd0, lnk.move_reject}, 32'd0);
    check("rst_move_pos", {28'd0, lnk.move_pos}, 32'd0);
    check("rst_reject_count", {24'd0, lnk.reject_count}, 32'd0);
    check("rst_greq", {31'd0, lnk.globalReset_req}, 32'd0);
    check("rst_rreq", {31'd0, lnk.regReset_req}, 32'd0);
    reset = 1'b1;

    // clean move at cell 4
    lnk.oppo_chesspos_rx = 4'd4;
    tick(30);
    expect_event(1'b1, 4'd4, 8'd0, 19);
    lnk.oppo_click_rx = 1'b1;
    tick(40);
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    check("clean_move_pos", {28'd0, lnk.move_pos}, 32'd4);
    check("clean_reject_count", {24'd0, lnk.reject_count}, 32'd0);

    // illegal cell 11
    lnk.oppo_chesspos_rx = 4'd11;
    tick(30);
    expect_event(1'b0, 4'd4, 8'd1, 19);
    lnk.oppo_click_rx = 1'b1;
    tick(25);
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    check("illegal_move_pos", {28'd0, lnk.move_pos}, 32'd4);
    check("illegal_reject_count", {24'd0, lnk.reject_count}, 32'd1);

    // short glitches and register reset forwarding
    lnk.oppo_click_rx = 1'b1;
    tick(10);
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    lnk.globalReset_rx = 1'b1;
    tick(15);
    lnk.globalReset_rx = 1'b0;
    for (int k = 0; k < 25; k++) begin
      check("glitch_greq", {31'd0, lnk.globalReset_req}, 32'd0);
      tick(1);
    end
    check("glitch_reject_count", {24'd0, lnk.reject_count}, 32'd1);
    lnk.regReset_rx = 1'b1;
    tick(17);
    check("rreq_before", {31'd0, lnk.regReset_req}, 32'd0);
    tick(1);
    check("rreq_after_18", {31'd0, lnk.regReset_req}, 32'd1);
    lnk.regReset_rx = 1'b0;
    tick(30);

    // late position settling at 2
    toggle_pos(20);
    expect_event(1'b1, 4'd2, 8'd1, -1);
    lnk.oppo_click_rx = 1'b1;
    toggle_pos(30);
    lnk.oppo_chesspos_rx = 4'd2;
    tick(50);
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    check("late_move_pos", {28'd0, lnk.move_pos}, 32'd2);

    // position never settles: timeout reject
    toggle_pos(20);
    expect_event(1'b0, 4'd2, 8'd2, -1);
    lnk.oppo_click_rx = 1'b1;
    toggle_pos(120);
    lnk.oppo_chesspos_rx = 4'd2;
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    check("timeout_reject_count", {24'd0, lnk.reject_count}, 32'd2);

    // global reset during WAIT_POS
    toggle_pos(20);
    lnk.oppo_click_rx = 1'b1;
    toggle_pos(25);
    lnk.globalReset_rx = 1'b1;
    toggle_pos(30);
    lnk.globalReset_rx = 1'b0;
    check("greq_high", {31'd0, lnk.globalReset_req}, 32'd1);
    lnk.oppo_chesspos_rx = 4'd2;
    tick(50);
    check("greq_dropped", {31'd0, lnk.globalReset_req}, 32'd0);
    check("greq_reject_count", {24'd0, lnk.reject_count}, 32'd0);
    check("greq_move_pos", {28'd0, lnk.move_pos}, 32'd0);
    lnk.oppo_click_rx = 1'b0;
    tick(30);
    expect_event(1'b1, 4'd2, 8'd0, 19);
    lnk.oppo_click_rx = 1'b1;
    tick(40);

    // reset mid-click
    lnk.oppo_click_rx = 1'b0;
    tick(10);
    lnk.oppo_click_rx = 1'b1;
    tick(10);
    reset = 1'b0;
    lnk.oppo_click_rx = 1'b0;
    tick(1);
    check("midrst_move_valid", {31'd0, lnk.move_valid}, 32'd0);
    check("midrst_move_pos", {28'd0, lnk.move_pos}, 32'd0);
    check("midrst_reject_count", {24'd0, lnk.reject_count}, 32'd0);
    tick(1);
    reset = 1'b1;

    // saturation of reject_count
    lnk.oppo_chesspos_rx = 4'd11;
    tick(30);
    for (int k = 0; k < 260; k++) begin
      expect_event(1'b0, 4'd0, (k >= 254) ? 8'd255 : 8'(k + 1), 19);
      lnk.oppo_click_rx = 1'b1;
      tick(20);
      lnk.oppo_click_rx = 1'b0;
      tick(20);
    end
    tick(10);
    check("sat_reject_count", {24'd0, lnk.reject_count}, 32'd255);
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
